// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine: operation
// codes, controller states and the iteration count of the radix-2 datapath.
package muldiv_pkg;

   localparam int ITERS = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Signed flavours take magnitudes and get a sign fix-up at the end
   function automatic logic isSignedOp(input op_e code);
      return (code == OP_MULT) || (code == OP_DIV);
   endfunction

   function automatic logic isDivOp(input op_e code);
      return (code == OP_DIV) || (code == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath shared by multiply and divide. A single
// 2*WIDTH register holds {partial product, multiplier} for MUL and
// {partial remainder, dividend/quotient} for DIV; each step_i advances
// the operation by one bit.
module muldiv_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               isDiv_i,
   input  logic [WIDTH-1:0]   aMag_i,
   input  logic [WIDTH-1:0]   bMag_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divPartial;
   logic [WIDTH:0]     divTrial;
   logic [2*WIDTH-1:0] divNext;

   // One shift-add or restoring-divide step, plus operand load
   always_comb begin
      mulSum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mulNext    = {mulSum, acc_q[WIDTH-1:1]};
      divPartial = acc_q[2*WIDTH-1:WIDTH-1];
      divTrial   = divPartial - {1'b0, b_q};
      if (!divTrial[WIDTH]) begin
         divNext = {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         divNext = {divPartial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      acc_d = acc_q;
      if (load_i) begin
         acc_d = {{WIDTH{1'b0}}, aMag_i};
      end else if (step_i) begin
         acc_d = isDiv_i ? divNext : mulNext;
      end
   end

   // Accumulator and divisor/multiplicand registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         if (load_i) begin
            b_q <= bMag_i;
         end
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU engine. Holds the pipeline with
// stall_ex for the whole operation, pulses done in the final cycle and
// writes the architectural HI/LO pair as it leaves that cycle. An exception
// flush abandons the operation without touching HI/LO.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             stall_ex,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CountWidth = $clog2(WIDTH);

   state_e                  state_q, state_d;
   logic [CountWidth-1:0]   count_q, count_d;
   logic                    isDiv_q, signA_q, signB_q, divZero_q;
   logic [WIDTH-1:0]        hi_q, lo_q, hi_d, lo_d;
   logic                    loadCore, stepCore, writeBack;
   op_e                     opCode;
   logic                    opIsDiv, opIsSigned;
   logic [WIDTH-1:0]        aMag, bMag;
   logic [2*WIDTH-1:0]      coreAcc, product;
   logic [WIDTH-1:0]        quotient, remainder;

   // Decode the incoming instruction and form operand magnitudes
   always_comb begin
      opCode     = op_e'(op);
      opIsDiv    = isDivOp(opCode);
      opIsSigned = isSignedOp(opCode);
      aMag       = (opIsSigned && a[WIDTH-1]) ? -a : a;
      bMag       = (opIsSigned && b[WIDTH-1]) ? -b : b;
   end

   // Controller next state; flush overrides everything including writeback
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      loadCore  = 1'b0;
      stepCore  = 1'b0;
      writeBack = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_BUSY;
               count_d  = CountWidth'(WIDTH - 1);
               loadCore = 1'b1;
            end
         end
         ST_BUSY: begin
            stepCore = 1'b1;
            if (count_q == '0) begin
               state_d = ST_DONE;
            end else begin
               count_d = count_q - CountWidth'(1);
            end
         end
         ST_DONE: begin
            writeBack = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush) begin
         state_d   = ST_IDLE;
         loadCore  = 1'b0;
         stepCore  = 1'b0;
         writeBack = 1'b0;
      end
   end

   // State and iteration counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Remember operation kind and operand signs for the final fix-up
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isDiv_q   <= 1'b0;
         signA_q   <= 1'b0;
         signB_q   <= 1'b0;
         divZero_q <= 1'b0;
      end else if (loadCore) begin
         isDiv_q   <= opIsDiv;
         signA_q   <= opIsSigned & a[WIDTH-1];
         signB_q   <= opIsSigned & b[WIDTH-1];
         divZero_q <= (b == '0);
      end
   end

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load_i  (loadCore),
      .step_i  (stepCore),
      .isDiv_i (isDiv_q),
      .aMag_i  (aMag),
      .bMag_i  (bMag),
      .acc_o   (coreAcc)
   );

   // Sign fix-up of the unsigned result; a zero divisor forces an all-ones quotient
   always_comb begin
      product   = (signA_q ^ signB_q) ? -coreAcc : coreAcc;
      quotient  = (signA_q ^ signB_q) ? -coreAcc[WIDTH-1:0] : coreAcc[WIDTH-1:0];
      if (divZero_q) begin
         quotient = '1;
      end
      remainder = signA_q ? -coreAcc[2*WIDTH-1:WIDTH] : coreAcc[2*WIDTH-1:WIDTH];
      hi_d      = isDiv_q ? remainder : product[2*WIDTH-1:WIDTH];
      lo_d      = isDiv_q ? quotient  : product[WIDTH-1:0];
   end

   // Architectural HI/LO, written only on leaving the done cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (writeBack) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign stall_ex = ((state_q == ST_IDLE) && start) || (state_q == ST_BUSY) || (state_q == ST_DONE);
   assign done     = (state_q == ST_DONE);
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a cycle-level occupancy model
// with plain-arithmetic results is compared every cycle, and directed
// vectors carry hand-computed HI/LO and latency expectations.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   localparam int LastCycle = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall_ex;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;
   int doneSeen = 0;

   int          occ     = 0;
   logic [63:0] pend    = '0;
   logic [31:0] expHi   = '0;
   logic [31:0] expLo   = '0;

   ex_muldiv_unit #(
      .WIDTH (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .stall_ex (stall_ex),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Architectural result of one instruction, returned as {HI, LO}
   function automatic logic [63:0] modelResult(input logic [1:0] opIn, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy;
      logic [63:0] ux, uy;
      int          dx, dy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (opIn)
         2'b00: return 64'(sx * sy);
         2'b01: return ux * uy;
         2'b10: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            dx = $signed(x);
            dy = $signed(y);
            return {32'(dx % dy), 32'(dx / dy)};
         end
         default: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Occupancy model: an instruction occupies EX for 34 cycles, cycle 33 is done
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         occ   <= 0;
         expHi <= '0;
         expLo <= '0;
      end else if (flush) begin
         occ <= 0;
      end else if (occ == 0) begin
         if (start) begin
            occ  <= 1;
            pend <= modelResult(op, a, b);
         end
      end else if (occ == LastCycle) begin
         occ            <= 0;
         {expHi, expLo} <= pend;
      end else begin
         occ <= occ + 1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      checkOutput("cyc_stall", 32'(stall_ex), 32'((occ != 0) || start));
      checkOutput("cyc_done",  32'(done),     32'(occ == LastCycle));
      checkOutput("cyc_hi",    hi,            expHi);
      checkOutput("cyc_lo",    lo,            expLo);
      if (done) doneSeen++;
   end

   // Issue one instruction (caller sits just after an edge) and hold start until done
   task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn, output int doneCycle);
      start = 1'b1;
      op    = opIn;
      a     = aIn;
      b     = bIn;
      #1;
      checkOutput("stall_cycle0", 32'(stall_ex), 32'h1);
      doneCycle = -1;
      for (int cyc = 0; cyc < 40 && doneCycle < 0; cyc++) begin
         @(negedge clk);
         if (done) doneCycle = cyc;
         @(posedge clk);
         #1;
         if (cyc == 0) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
         end
      end
   endtask

   task automatic runOp(input string name, input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                        input logic [31:0] wantHi, input logic [31:0] wantLo);
      int dc;
      applyStimulus(opIn, aIn, bIn, dc);
      start = 1'b0;
      #1;
      checkOutput({name, "_doneCycle"}, 32'(dc), 32'd33);
      checkOutput({name, "_hi"}, hi, wantHi);
      checkOutput({name, "_lo"}, lo, wantLo);
      checkOutput({name, "_stallIdle"}, 32'(stall_ex), 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      int dc1, dc2, seenBefore;
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_hi",    hi,             32'h0);
      checkOutput("reset_lo",    lo,             32'h0);
      checkOutput("reset_done",  32'(done),      32'h0);
      checkOutput("reset_stall", 32'(stall_ex),  32'h0);
      rst = 1'b0;
      idleCycles(1);

      $display("[TB] directed arithmetic vectors");
      runOp("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      runOp("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      runOp("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("divu_small", OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
      runOp("div_zero",   OP_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
      runOp("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      runOp("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      runOp("div_negb",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      runOp("div_negzero",OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      $display("[TB] flush in busy cycle 10");
      seenBefore = doneSeen;
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'd5;
      b     = 32'd6;
      idleCycles(10);
      flush = 1'b1;
      idleCycles(1);
      flush = 1'b0;
      start = 1'b0;
      #1;
      checkOutput("flushBusy_stall", 32'(stall_ex), 32'h0);
      checkOutput("flushBusy_done",  32'(done),     32'h0);
      idleCycles(40);
      checkOutput("flushBusy_hi",    hi, 32'hFFFF_FFF9);
      checkOutput("flushBusy_lo",    lo, 32'hFFFF_FFFF);
      checkOutput("flushBusy_noDone", 32'(doneSeen - seenBefore), 32'h0);

      $display("[TB] flush during done cycle");
      start = 1'b1;
      op    = OP_DIVU;
      a     = 32'd100;
      b     = 32'd7;
      idleCycles(33);
      checkOutput("flushDone_doneHigh", 32'(done), 32'h1);
      flush = 1'b1;
      idleCycles(1);
      flush = 1'b0;
      start = 1'b0;
      #1;
      checkOutput("flushDone_hi", hi, 32'hFFFF_FFF9);
      checkOutput("flushDone_lo", lo, 32'hFFFF_FFFF);
      idleCycles(2);

      $display("[TB] flush together with start");
      seenBefore = doneSeen;
      start = 1'b1;
      flush = 1'b1;
      op    = OP_MULTU;
      a     = 32'd9;
      b     = 32'd9;
      idleCycles(1);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("flushStart_stall", 32'(stall_ex), 32'h0);
      idleCycles(36);
      checkOutput("flushStart_noDone", 32'(doneSeen - seenBefore), 32'h0);
      checkOutput("flushStart_lo", lo, 32'hFFFF_FFFF);

      $display("[TB] back-to-back MULTU");
      applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000, dc1);
      checkOutput("b2b_first_doneCycle", 32'(dc1), 32'd33);
      checkOutput("b2b_first_hi", hi, 32'h0000_0001);
      checkOutput("b2b_first_lo", lo, 32'h0000_0000);
      applyStimulus(OP_MULTU, 32'h0000_FFFF, 32'h0000_0003, dc2);
      start = 1'b0;
      #1;
      checkOutput("b2b_second_doneCycle", 32'(dc1 + 1 + dc2), 32'd67);
      checkOutput("b2b_second_hi", hi, 32'h0000_0000);
      checkOutput("b2b_second_lo", lo, 32'h0002_FFFD);
      idleCycles(2);

      $display("[TB] reset during busy");
      seenBefore = doneSeen;
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'h1234_5678;
      b     = 32'h0000_0010;
      idleCycles(5);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      #1;
      checkOutput("rstBusy_hi",    hi,            32'h0);
      checkOutput("rstBusy_lo",    lo,            32'h0);
      checkOutput("rstBusy_stall", 32'(stall_ex), 32'h0);
      idleCycles(1);
      rst = 1'b0;
      idleCycles(40);
      checkOutput("rstBusy_noDone", 32'(doneSeen - seenBefore), 32'h0);
      checkOutput("rstBusy_hiAfter", hi, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
